seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 27 ++
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared widths, FSM states and helpers for the sequential divider.
// Optional DIV_ZERO_FLAG_EN adds the div_by_zero output to seq_divider.
package div_pkg;

    localparam int DVD_W_DEF = 8;
    localparam int DVS_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Width of an iteration counter covering 0..n-1, never zero.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial
// subtract the divisor, keep or restore, emit the quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic [DVS_W-1:0] rem_in,
    input  logic             bit_in,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W-1:0] rem_out,
    output logic             q_bit
);

    logic [DVS_W:0]   shifted;
    logic [DVS_W-1:0] diff;

    // When the trial succeeds the true difference is below the divisor,
    // so its low DVS_W bits are exact and the carry-out can be dropped.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted[DVS_W-1:0] - divisor;
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? diff : shifted[DVS_W-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one dividend bit per clock.
// Define DIV_ZERO_FLAG_EN to add the registered div_by_zero output.
module seq_divider
    import div_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
`ifdef DIV_ZERO_FLAG_EN
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
`else
    output logic [DVS_W-1:0] remainder
`endif
);

    localparam int CNT_W = cnt_width(DVD_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DVD_W - 1);

    div_state_t       state;
    div_state_t       state_nxt;
    logic             accept;
    logic [CNT_W-1:0] iter;
    logic [DVD_W-1:0] dvd_sr;
    logic [DVD_W-1:0] quot_q;
    logic [DVS_W-1:0] dvs_q;
    logic [DVS_W-1:0] rem_q;
    logic [DVS_W-1:0] rem_step;
    logic             q_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Start is only honoured in IDLE and DONE; in RUN it is invisible.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (iter == LAST_ITER) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    div_step #(
        .DVS_W(DVS_W)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_sr[DVD_W-1]),
        .divisor (dvs_q),
        .rem_out (rem_step),
        .q_bit   (q_bit)
    );

    // Dividend bits leave the top of dvd_sr while quotient bits enter
    // at the bottom of quot_q, so both stay MSB-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter   <= '0;
            dvd_sr <= '0;
            dvs_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
        end else if (accept) begin
            iter   <= '0;
            dvd_sr <= dividend;
            dvs_q  <= divisor;
            quot_q <= '0;
            rem_q  <= '0;
        end else if (state == RUN) begin
            iter   <= iter + CNT_W'(1);
            dvd_sr <= dvd_sr << 1;
            quot_q <= (quot_q << 1) | DVD_W'(q_bit);
            rem_q  <= rem_step;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;

`ifdef DIV_ZERO_FLAG_EN
    logic dz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dz_q <= 1'b0;
        end else if (accept) begin
            dz_q <= (divisor == '0);
        end
    end

    assign div_by_zero = dz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, exhaustive sweep
// and randomized traffic against an arithmetic reference model.
module tb_seq_divider;

    localparam int DVD_W = 8;
    localparam int DVS_W = 4;
    localparam int TMO   = 40;

    logic             clk;
    logic             rst;
    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
    logic             div_by_zero;
`endif

    int n_vec = 0;
    int n_err = 0;

    seq_divider #(
        .DVD_W(DVD_W),
        .DVS_W(DVS_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
`ifdef DIV_ZERO_FLAG_EN
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
`else
        .remainder  (remainder)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Plain arithmetic; divisor 0 yields all-ones and the low dividend bits.
    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r);
        if (b == 0) begin
            q = (1 << DVD_W) - 1;
            r = a % (1 << DVS_W);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic fire(input int a, input int b);
        start    = 1'b1;
        dividend = DVD_W'(a);
        divisor  = DVS_W'(b);
    endtask

    task automatic issue(input int a, input int b);
        @(negedge clk);
        fire(a, b);
    endtask

    // Called right after the accepting edge; waits for done and checks.
    task automatic collect(input int a, input int b, input bit noise,
                           input int poke_at, input bit ident);
        int lat;
        int nb;
        int ov;
        int eq;
        int er;
        string t;
        lat = 0;
        nb  = 0;
        ov  = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) nb++;
            if (busy && done) ov++;
            start = 1'b0;
            if (lat == poke_at) begin
                fire(50, 3);
            end else if (noise && lat <= DVD_W) begin
                start    = 1'($urandom);
                dividend = DVD_W'($urandom);
                divisor  = DVS_W'($urandom);
            end
        end while (!done && lat < TMO);
        ref_div(a, b, eq, er);
        t = $sformatf("%0d/%0d", a, b);
        chk({"latency ", t}, 32'(lat), 32'(DVD_W + 1));
        chk({"busy_cycles ", t}, 32'(nb), 32'(DVD_W));
        chk({"busy_and_done ", t}, 32'(ov), 32'd0);
        chk({"quotient ", t}, 32'(quotient), 32'(eq));
        chk({"remainder ", t}, 32'(remainder), 32'(er));
`ifdef DIV_ZERO_FLAG_EN
        chk({"div_by_zero ", t}, 32'(div_by_zero), 32'(b == 0));
`endif
        if (ident && b != 0) begin
            chk({"identity ", t}, 32'(int'(quotient) * b + int'(remainder)),
                32'(a));
            chk({"rem_lt_div ", t}, 32'(int'(remainder) < b), 32'd1);
        end
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " quotient"}, 32'(quotient), 32'd0);
        chk({tag, " remainder"}, 32'(remainder), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'd0);
`endif
    endtask

    initial begin
        int ndone;
        int a;
        int b;
        bit b2b;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        zero_outputs("reset");
        rst = 1'b0;

        issue(200, 13);
        collect(200, 13, 1'b0, 0, 1'b1);
        @(negedge clk);
        chk("hold quotient", 32'(quotient), 32'd15);
        chk("hold remainder", 32'(remainder), 32'd5);
        chk("hold done", 32'(done), 32'd0);
        chk("hold busy", 32'(busy), 32'd0);

        issue(255, 1);
        collect(255, 1, 1'b0, 0, 1'b1);
        issue(0, 7);
        collect(0, 7, 1'b0, 0, 1'b1);
        issue(100, 0);
        collect(100, 0, 1'b0, 0, 1'b1);

        issue(200, 13);
        collect(200, 13, 1'b0, 3, 1'b1);

        issue(200, 13);
        collect(200, 13, 1'b0, 0, 1'b1);
        fire(50, 3);
        collect(50, 3, 1'b0, 0, 1'b1);

        issue(200, 13);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 zero_outputs("abort");
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort no_done", 32'(ndone), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fire(77, 6);
        collect(77, 6, 1'b0, 0, 1'b1);

        for (int i = 0; i < (1 << DVD_W); i++) begin
            for (int j = 0; j < (1 << DVS_W); j++) begin
                issue(i, j);
                collect(i, j, 1'b0, 0, 1'b1);
            end
        end

        b2b = 1'b0;
        repeat (300) begin
            a = int'($urandom_range((1 << DVD_W) - 1, 0));
            b = int'($urandom_range((1 << DVS_W) - 1, 0));
            if (b2b) begin
                fire(a, b);
            end else begin
                repeat ($urandom_range(2, 0)) @(negedge clk);
                issue(a, b);
            end
            collect(a, b, 1'($urandom), 0, 1'b1);
            b2b = ($urandom_range(3, 0) == 0);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
